// File: rtl/sync_fifo_rv.sv
// sync_fifo_rv: parametrised synchronous FIFO with ready/valid on both sides.
// Storage is a distributed-RAM array written on the rising edge and read
// combinationally, so the head entry falls through to deq_data as soon as
// it has been written. Pointers carry one extra wrap bit so that full and
// empty can be told apart without a separate flag.
//
// Optional feature: define FIFO_ALMOST_FLAGS_EN to add the registered
// almost_full / almost_empty outputs. Without it those ports and their logic
// are absent and the ALMOST_* parameters are only range-checked.
module sync_fifo_rv #(
  parameter int WIDTH              = 32,
  parameter int LOGDEPTH           = 3,
  parameter int ALMOST_FULL_LEVEL  = (1 << LOGDEPTH) - 1,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enq_valid,
  input  logic [WIDTH-1:0]    enq_data,
  output logic                enq_ready,
  output logic                deq_valid,
  output logic [WIDTH-1:0]    deq_data,
  input  logic                deq_ready,
  output logic [LOGDEPTH:0]   count
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic                almost_full,
  output logic                almost_empty
`endif
);

  localparam int DEPTH = 1 << LOGDEPTH;

  // Pointer increment and the occupancy value that means "full", both sized
  // to the pointer width so arithmetic and compares stay width-matched.
  localparam logic [LOGDEPTH:0] PTR_ONE   = {{LOGDEPTH{1'b0}}, 1'b1};
  localparam logic [LOGDEPTH:0] DEPTH_CNT = {1'b1, {LOGDEPTH{1'b0}}};

  // Reject configurations the pointer scheme and flag compares cannot honour.
  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("sync_fifo_rv: WIDTH must be at least 1");
    end
    if (LOGDEPTH < 1 || LOGDEPTH > 10) begin : g_bad_logdepth
      $error("sync_fifo_rv: LOGDEPTH must be in 1..10");
    end
    if (ALMOST_FULL_LEVEL < 0 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_af
      $error("sync_fifo_rv: ALMOST_FULL_LEVEL must be in 0..DEPTH");
    end
    if (ALMOST_EMPTY_LEVEL < 0 || ALMOST_EMPTY_LEVEL > DEPTH) begin : g_bad_ae
      $error("sync_fifo_rv: ALMOST_EMPTY_LEVEL must be in 0..DEPTH");
    end
  endgenerate

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [WIDTH-1:0]    mem_reg [DEPTH];
  logic [LOGDEPTH:0]   wr_ptr_reg;
  logic [LOGDEPTH:0]   wr_ptr_next;
  logic [LOGDEPTH:0]   rd_ptr_reg;
  logic [LOGDEPTH:0]   rd_ptr_next;
  logic [LOGDEPTH:0]   count_reg;
  logic [LOGDEPTH:0]   count_next;

  logic [LOGDEPTH-1:0] wr_idx;
  logic [LOGDEPTH-1:0] rd_idx;
  logic                full;
  logic                empty;
  logic                enq_fire;
  logic                deq_fire;

  // ------------------------------------------------------------------
  // Status and handshakes: derived from registered pointers only, so
  // enq_ready / deq_valid never depend combinationally on the inputs.
  // ------------------------------------------------------------------
  assign wr_idx    = wr_ptr_reg[LOGDEPTH-1:0];
  assign rd_idx    = rd_ptr_reg[LOGDEPTH-1:0];
  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_idx == rd_idx) &&
                     (wr_ptr_reg[LOGDEPTH] != rd_ptr_reg[LOGDEPTH]);
  assign enq_ready = !full;
  assign deq_valid = !empty;

  // A cycle with rst high discards everything, so no transfer may fire in it.
  assign enq_fire  = enq_valid && !full  && !rst;
  assign deq_fire  = deq_ready && !empty && !rst;

  // Head entry falls through combinationally; undefined while empty.
  assign deq_data  = mem_reg[rd_idx];
  assign count     = count_reg;

  // Next pointer values and the occupancy they imply.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (enq_fire) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (deq_fire) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end
    count_next = wr_ptr_next - rd_ptr_next;
  end

  // Pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage write port; contents are deliberately left alone on reset.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem_reg[wr_idx] <= enq_data;
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [LOGDEPTH:0] AF_LVL = ALMOST_FULL_LEVEL[LOGDEPTH:0];
  localparam logic [LOGDEPTH:0] AE_LVL = ALMOST_EMPTY_LEVEL[LOGDEPTH:0];

  logic almost_full_reg;
  logic almost_empty_reg;

  // Flags are computed from next-state occupancy so they line up with count.
  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
    end else begin
      almost_full_reg  <= (count_next >= AF_LVL);
      almost_empty_reg <= (count_next <= AE_LVL);
    end
  end

  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;
`endif

  // ------------------------------------------------------------------
  // Structural invariants
  // ------------------------------------------------------------------
  a_count_bounded: assert property (@(posedge clk) disable iff (rst)
    count_reg <= DEPTH_CNT);

  a_full_means_depth: assert property (@(posedge clk) disable iff (rst)
    (deq_valid && full) |-> (count_reg == DEPTH_CNT));

  a_count_tracks_ptrs: assert property (@(posedge clk) disable iff (rst)
    count_reg == (wr_ptr_reg - rd_ptr_reg));

endmodule

// File: tb/tb_sync_fifo_rv.sv
// Bench for sync_fifo_rv (WIDTH=8, LOGDEPTH=2). A driver applies directed
// sequences then random traffic; a monitor on the falling edge compares
// the DUT against a queue-based reference and updates that queue for the
// coming rising edge.
module tb_sync_fifo_rv;

  localparam int WIDTH    = 8;
  localparam int LOGDEPTH = 2;
  localparam int DEPTH    = 4;

  logic               clk       = 1'b0;
  logic               rst       = 1'b1;
  logic               enq_valid = 1'b0;
  logic [WIDTH-1:0]   enq_data  = '0;
  logic               deq_ready = 1'b0;
  logic               enq_ready;
  logic               deq_valid;
  logic [WIDTH-1:0]   deq_data;
  logic [LOGDEPTH:0]  count;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic               almost_full;
  logic               almost_empty;
`endif

  always #5 clk = ~clk;

  sync_fifo_rv #(
    .WIDTH              (WIDTH),
    .LOGDEPTH           (LOGDEPTH),
    .ALMOST_FULL_LEVEL  (3),
    .ALMOST_EMPTY_LEVEL (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enq_valid    (enq_valid),
    .enq_data     (enq_data),
    .enq_ready    (enq_ready),
    .deq_valid    (deq_valid),
    .deq_data     (deq_data),
    .deq_ready    (deq_ready),
    .count        (count)
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  int tests = 0;
  int fails = 0;
  bit model_live = 1'b0;
  logic [WIDTH-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: compare this cycle's outputs with the reference,
  // then apply this cycle's transfers to the reference.
  always @(negedge clk) begin
    int occ;
    bit e_fire;
    bit d_fire;
    logic [WIDTH-1:0] popped;
    occ = exp_q.size();
    if (model_live) begin
      chk("count", 32'(count), 32'(occ));
      chk("enq_ready", 32'(enq_ready), 32'(occ < DEPTH));
      chk("deq_valid", 32'(deq_valid), 32'(occ > 0));
`ifdef FIFO_ALMOST_FLAGS_EN
      chk("almost_full", 32'(almost_full), 32'(occ >= 3));
      chk("almost_empty", 32'(almost_empty), 32'(occ <= 1));
`endif
      if (occ > 0) begin
        chk("deq_data", 32'(deq_data), 32'(exp_q[0]));
      end
    end
    if (rst) begin
      exp_q.delete();
      model_live = 1'b1;
      $display("[TB] t=%0t reset", $time);
    end else if (model_live) begin
      d_fire = deq_ready && (occ > 0);
      e_fire = enq_valid && (occ < DEPTH);
      if (d_fire) begin
        popped = exp_q.pop_front();
        $display("[TB] t=%0t deq %02h", $time, popped);
      end
      if (e_fire) begin
        exp_q.push_back(enq_data);
        $display("[TB] t=%0t enq %02h", $time, enq_data);
      end
    end
  end

  // One clock cycle of stimulus, driven just after the rising edge.
  task automatic cyc(input logic r, input logic ev, input logic [WIDTH-1:0] d, input logic dr);
    rst       = r;
    enq_valid = ev;
    enq_data  = d;
    deq_ready = dr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] fill_vals [4];
    fill_vals[0] = 8'h11; fill_vals[1] = 8'h22;
    fill_vals[2] = 8'h33; fill_vals[3] = 8'h44;

    cyc(1, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 0);

    // Fill to full, then offer a fifth word that must be refused.
    for (int i = 0; i < 4; i++) cyc(0, 1, fill_vals[i], 0);
    cyc(0, 1, 8'h55, 0);
    cyc(0, 0, 8'h00, 0);

    // Drain in order, then one idle cycle showing empty.
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);

    // Fall-through latency into an empty FIFO.
    cyc(0, 1, 8'hA0, 0);
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 1);

    // Hold occupancy at 2 with simultaneous transfers; pointers wrap.
    cyc(0, 1, 8'hE0, 0);
    cyc(0, 1, 8'hE1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 8'(i), 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 1);

    // Reset mid-operation with both handshakes active.
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'(8'hC0 + i), 0);
    cyc(1, 1, 8'h77, 1);
    cyc(0, 1, 8'h5A, 0);
    cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 0);

    // Fill 0 -> 4 and back for the occupancy flags.
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'(8'h60 + i), 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 1);

    // Random traffic: producer-heavy phase, then consumer-heavy phase.
    for (int i = 0; i < 1500; i++) begin
      int pe;
      int pd;
      pe = (i < 750) ? 70 : 35;
      pd = (i < 750) ? 35 : 70;
      cyc(($urandom_range(0, 249) == 0),
          ($urandom_range(0, 99) < pe),
          8'($urandom),
          ($urandom_range(0, 99) < pd));
    end

    for (int i = 0; i < 8; i++) cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo_rv.md
Name: sync_fifo_rv

Overview:
- Parametrised synchronous FIFO with ready/valid handshakes on both sides. Generalises the single-port RAM primitives into a buffered queue.
- Sits between pipeline stages and between cores and MMIO/UART paths to decouple producer and consumer.
- Storage is a distributed-RAM array: write on the clock edge, combinational read (first-word-fall-through).
- State elements are the storage array, read/write pointers and the occupancy count.

Parameters:
- WIDTH, 32, data width in bits.
- LOGDEPTH, 3, log2 of depth; DEPTH = 1 << LOGDEPTH. Legal range is 1..10.
- ALMOST_FULL_LEVEL, DEPTH-1, occupancy at or above which almost_full asserts (optional feature only).
- ALMOST_EMPTY_LEVEL, 1, occupancy at or below which almost_empty asserts (optional feature only).

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- enq_valid  input  1  producer presents enq_data.
- enq_data  input  WIDTH  data to enqueue.
- enq_ready  output  1  FIFO can accept; high when not full.
- deq_valid  output  1  deq_data is valid; high when not empty.
- deq_data  output  WIDTH  head entry, combinational from storage.
- deq_ready  input  1  consumer accepts the head entry.
- count  output  LOGDEPTH+1  current occupancy, 0..DEPTH.
- almost_full  output  1  present only with FIFO_ALMOST_FLAGS_EN.
- almost_empty  output  1  present only with FIFO_ALMOST_FLAGS_EN.

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Pointers:
  - wr_ptr and rd_ptr are LOGDEPTH+1 bits; the MSB is the wrap bit and the low LOGDEPTH bits index storage.
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and MSBs differ.
  - count = wr_ptr - rd_ptr, modulo 2^(LOGDEPTH+1).
- Handshake:
  - enq fire = enq_valid & enq_ready.
  - deq fire = deq_valid & deq_ready.
  - enq_ready = !full; deq_valid = !empty. Both depend only on state, never combinationally on enq_valid or deq_ready.
  - Producer and consumer may hold or drop valid/ready freely. No data is lost or duplicated.
- Enqueue: on enq fire, at the edge mem[wr_ptr] <= enq_data and wr_ptr increments.
- Dequeue: on deq fire, at the edge rd_ptr increments. deq_data always equals mem[rd_ptr low bits].
- Latency:
  - An entry enqueued into an empty FIFO at edge N has deq_valid=1 and deq_data visible in the cycle after edge N.
  - There is no same-cycle enq-to-deq bypass.
- Simultaneous enq and deq fire:
  - Both pointers advance and count is unchanged.
  - This is legal at any occupancy between 1 and DEPTH-1.
  - At full, enq_ready=0, so only the deq occurs.
  - At empty, deq_valid=0, so only the enq occurs.
- Wrap-around: pointers roll from 2^(LOGDEPTH+1)-1 to 0. Ordering is preserved across the wrap.
- Reset:
  - Values while rst=1 and after: wr_ptr=0, rd_ptr=0, count=0, enq_ready=1, deq_valid=0. Optional outputs: almost_full=0, almost_empty=1.
  - Storage contents are not cleared; deq_data is undefined while empty.
  - Reset asserted mid-operation discards all entries at that edge. Any enq or deq fire in the same cycle as rst=1 is ignored.
- Ordering: strict FIFO.
- Assertions: deq_valid & full never shows count != DEPTH. count never exceeds DEPTH.

Optional Feature:
- Macro FIFO_ALMOST_FLAGS_EN.
- When defined:
  - Ports almost_full and almost_empty exist.
  - almost_full = (count >= ALMOST_FULL_LEVEL); almost_empty = (count <= ALMOST_EMPTY_LEVEL).
  - Both are registered, computed from next-state count, so they are aligned with count and carry no combinational path from inputs.
- When undefined:
  - The ports and logic are absent.
  - ALMOST_* parameters are accepted but unused.

Test Plan:
- WIDTH=8, LOGDEPTH=2:
  - Stimulus: after reset, enqueue 0x11, 0x22, 0x33, 0x44 with deq_ready=0.
  - Required: count goes 1, 2, 3, 4; enq_ready=0 after the 4th edge; a 5th enq_valid with 0x55 is not accepted.
- Drain a full FIFO with deq_ready=1 -> deq_data sequence 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then deq_valid=0 and count=0.
- Stimulus: enqueue 0xA0 into an empty FIFO.
  - Required: deq_valid=0 in the same cycle; deq_valid=1 with deq_data=0xA0 the next cycle.
- Stimulus: hold occupancy at 2 with simultaneous enq/deq fire for 10 cycles, data 0x00..0x09, so pointers wrap twice.
  - Required: count stays 2 and outputs appear in order with no loss.
- Stimulus: fill 3 entries, then assert rst for 1 cycle while enq_valid=1 and deq_ready=1.
  - Required: count=0, deq_valid=0, enq_ready=1. The next enqueue of 0x5A dequeues as 0x5A.
- With FIFO_ALMOST_FLAGS_EN, ALMOST_FULL_LEVEL=3, ALMOST_EMPTY_LEVEL=1:
  - Stimulus: fill from 0 to 4.
  - Required: almost_empty=1 at count 0 and 1, then 0. almost_full=0 at counts 0–2, then 1 at counts 3 and 4.
